dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters with round-robin arbitration:

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter sharing a single-port data memory between
//            port A (CPU) and port B (loader/debug), with address-window check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int unsigned        ADDR_W = 32,
  parameter int unsigned        DATA_W = 32,
  parameter logic [ADDR_W-1:0]  MEM_LO = ADDR_W'('h3000),
  parameter logic [ADDR_W-1:0]  MEM_HI = ADDR_W'('h3fff)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_b_q, grant_b_d;
  logic                last_b_q, last_b_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                sel_b;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_in_range;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    sel_b        = (a_req && b_req) ? ~last_b_q : b_req;
    sel_we       = sel_b ? b_we    : a_we;
    sel_addr     = sel_b ? b_addr  : a_addr;
    sel_wdata    = sel_b ? b_wdata : a_wdata;
    sel_in_range = (sel_addr >= MEM_LO) && (sel_addr <= MEM_HI);
  end

  always_comb begin
    state_d   = state_q;
    grant_b_d = grant_b_q;
    last_b_d  = last_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          grant_b_d = sel_b;
          last_b_d  = sel_b;
          we_d      = sel_we;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          err_d     = ~sel_in_range;
          rdata_d   = '0;
          state_d   = sel_in_range ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          rdata_d = mem_rdata;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_b_q <= grant_b_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // The write strobe is gated by reset so an aborted write never commits.
  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    a_ack       = 1'b0;
    a_err       = 1'b0;
    a_rdata     = '0;
    b_ack       = 1'b0;
    b_err       = 1'b0;
    b_rdata     = '0;
    case (state_q)
      S_ACCESS: begin
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        mem_we      = we_q & ~reset;
        mem_re      = ~we_q;
      end
      S_RESP: begin
        if (grant_b_q) begin
          b_ack   = 1'b1;
          b_err   = err_q;
          b_rdata = rdata_q;
        end else begin
          a_ack   = 1'b1;
          a_err   = err_q;
          a_rdata = rdata_q;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a transaction-level
//            schedule model and a behavioural data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_ack, a_err;
  logic [31:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_ack, b_err;
  logic [31:0] b_rdata;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural data memory (combinational read, write at edge)
  bit          init_done = 1'b0;
  logic [31:0] dmem    [0:4095];
  logic [31:0] ref_mem [0:4095];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) dmem[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_we) begin
      dmem[mem_address[11:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_re ? dmem[mem_address[11:0]] : 32'h0;

  // Model: each grant schedules one expectation record per busy cycle.
  typedef struct {
    bit          port_b;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          access;
    bit          err;
    logic [31:0] rdata;
  } rec_t;

  rec_t sched[$];
  bit   m_last_b = 1'b1;
  rec_t m_r;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h3000) && (a <= 32'h3fff);
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    if (reset) begin
      sched.delete();
      m_last_b = 1'b1;
    end else if (sched.size() != 0) begin
      m_r = sched.pop_front();
      if (m_r.access && m_r.we) ref_mem[m_r.addr[11:0]] = m_r.wdata;
    end else if (a_req || b_req) begin
      m_r.port_b = (a_req && b_req) ? !m_last_b : b_req;
      m_last_b   = m_r.port_b;
      m_r.we     = m_r.port_b ? b_we    : a_we;
      m_r.addr   = m_r.port_b ? b_addr  : a_addr;
      m_r.wdata  = m_r.port_b ? b_wdata : a_wdata;
      m_r.err    = !in_win(m_r.addr);
      m_r.rdata  = (!m_r.err && !m_r.we) ? ref_mem[m_r.addr[11:0]] : 32'h0;
      if (!m_r.err) begin
        m_r.access = 1'b1;
        sched.push_back(m_r);
      end
      m_r.access = 1'b0;
      sched.push_back(m_r);
    end
  end

  int a_ack_cnt = 0, b_ack_cnt = 0, strobe_cnt = 0;
  rec_t e;
  logic [31:0] e_addr, e_wdata, e_ard, e_brd;
  logic e_we, e_re, e_aack, e_aerr, e_back, e_berr;

  always @(negedge clk) begin
    e_addr = '0; e_wdata = '0; e_we = 0; e_re = 0;
    e_aack = 0; e_aerr = 0; e_ard = '0; e_back = 0; e_berr = 0; e_brd = '0;
    if (sched.size() != 0) begin
      e = sched[0];
      if (e.access) begin
        e_addr = e.addr; e_wdata = e.wdata;
        e_we = e.we && !reset; e_re = !e.we;
      end else if (e.port_b) begin
        e_back = 1; e_berr = e.err; e_brd = e.rdata;
      end else begin
        e_aack = 1; e_aerr = e.err; e_ard = e.rdata;
      end
    end
    chk("mem_address", mem_address, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_re", 32'(mem_re), 32'(e_re));
    chk("a_ack", 32'(a_ack), 32'(e_aack));
    chk("a_err", 32'(a_err), 32'(e_aerr));
    chk("a_rdata", a_rdata, e_ard);
    chk("b_ack", 32'(b_ack), 32'(e_back));
    chk("b_err", 32'(b_err), 32'(e_berr));
    chk("b_rdata", b_rdata, e_brd);
    if (a_ack) a_ack_cnt++;
    if (b_ack) b_ack_cnt++;
    if (mem_we || mem_re) strobe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input bit pb, input bit we, input logic [31:0] ad, input logic [31:0] wd);
    if (pb) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
    else    begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
  endtask

  task automatic wait_ack(input bit pb, output bit err, output logic [31:0] rd, output int lat);
    bit got = 0;
    lat = 0; err = 0; rd = '0;
    while (!got && lat < 8) begin
      tick();
      lat++;
      if (pb ? b_ack : a_ack) begin
        got = 1;
        err = pb ? b_err : a_err;
        rd  = pb ? b_rdata : a_rdata;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: port %0d got no ack within 8 cycles", pb);
    end
    if (pb) b_req = 0; else a_req = 0;
    tick();
  endtask

  task automatic xact(input bit pb, input bit we, input logic [31:0] ad, input logic [31:0] wd,
                      output bit err, output logic [31:0] rd, output int lat);
    start(pb, we, ad, wd);
    wait_ack(pb, err, rd, lat);
  endtask

  bit          r_err;
  logic [31:0] r_rd;
  int          r_lat;
  int          snap;
  bit          glog[$];
  logic [31:0] dlog[$];
  int          nbad;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    init_done = 1;
    tick(); tick();
    chk("rst_a_ack", 32'(a_ack), 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    reset = 0;
    tick();

    // Write then read back through port A
    xact(0, 1, 32'h3000, 32'hDEADBEEF, r_err, r_rd, r_lat);
    chk("wr_err", 32'(r_err), 32'h0);
    chk("wr_lat", 32'(r_lat), 32'd2);
    chk("wr_rdata", r_rd, 32'h0);
    xact(0, 0, 32'h3000, 32'h0, r_err, r_rd, r_lat);
    chk("rd_data", r_rd, 32'hDEADBEEF);
    chk("rd_lat", 32'(r_lat), 32'd2);

    // Continuous contention alternates grants, starting with A after reset
    reset = 1; tick(); reset = 0;
    a_req = 1; a_we = 0; a_addr = 32'h3001;
    b_req = 1; b_we = 0; b_addr = 32'h3002;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_ack) begin glog.push_back(0); dlog.push_back(a_rdata); end
      if (b_ack) begin glog.push_back(1); dlog.push_back(b_rdata); end
    end
    a_req = 0; b_req = 0;
    tick(); tick();
    chk("rr_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      chk("rr_order", 32'(glog[i]), 32'(i % 2));
      chk("rr_rdata", dlog[i], (i % 2 == 0) ? 32'h1000_0001 : 32'h1000_0002);
    end

    // Out-of-window requests on B
    snap = strobe_cnt;
    xact(1, 0, 32'h2FFF, 32'h0, r_err, r_rd, r_lat);
    chk("lo_err", 32'(r_err), 32'h1);
    chk("lo_lat", 32'(r_lat), 32'd1);
    chk("lo_rdata", r_rd, 32'h0);
    xact(1, 1, 32'h4000, 32'h1234_5678, r_err, r_rd, r_lat);
    chk("hi_err", 32'(r_err), 32'h1);
    chk("hi_lat", 32'(r_lat), 32'd1);
    chk("err_strobes", 32'(strobe_cnt - snap), 32'd0);

    // Reset during the ACCESS cycle of a write aborts it
    snap = a_ack_cnt;
    start(0, 1, 32'h3010, 32'h55);
    tick();
    reset = 1; a_req = 0;
    tick();
    reset = 0;
    tick(); tick(); tick();
    chk("abort_noack", 32'(a_ack_cnt - snap), 32'd0);
    xact(0, 0, 32'h3010, 32'h0, r_err, r_rd, r_lat);
    chk("abort_rd", r_rd, 32'h1000_0010);
    chk("abort_lat", 32'(r_lat), 32'd2);

    // Field changes after grant do not affect the access in flight
    start(0, 1, 32'h3020, 32'h0000_AAAA);
    tick();
    a_addr = 32'h3021; a_wdata = 32'h0000_BBBB;
    wait_ack(0, r_err, r_rd, r_lat);
    chk("lat_chg_lat", 32'(r_lat), 32'd1);
    xact(0, 0, 32'h3020, 32'h0, r_err, r_rd, r_lat);
    chk("latched_wr", r_rd, 32'h0000_AAAA);
    xact(0, 0, 32'h3021, 32'h0, r_err, r_rd, r_lat);
    chk("untouched", r_rd, 32'h1000_0021);

    // Window boundaries
    xact(1, 0, 32'h3000, 32'h0, r_err, r_rd, r_lat);
    chk("lo_edge_err", 32'(r_err), 32'h0);
    chk("lo_edge_rd", r_rd, 32'hDEADBEEF);
    xact(0, 0, 32'h3fff, 32'h0, r_err, r_rd, r_lat);
    chk("hi_edge_err", 32'(r_err), 32'h0);
    chk("hi_edge_rd", r_rd, 32'h1000_0fff);

    nbad = 0;
    for (int i = 0; i < 4096; i++) if (dmem[i] !== ref_mem[i]) nbad++;
    chk("mem_image", 32'(nbad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
